wishbone_slave_xactor: RTL and testbench

- Wishbone B4 pipelined slave transactor. It is the responder counterpart of the master transactor.
- Accepts bus requests from an external master and queues them to a client through a BSV-style get interface.
- Returns client responses as ACK_O/DAT_O.
- Sits at the bus-facing edge of peripherals and memories that implement the client side.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_sync_fifo.sv | 52 +++++
 rtl/wishbone_slave_xactor.sv | 146 ++++++++++++++
 tb/tb_wishbone_slave_xactor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants, request layout and FSM state type for the Wishbone slave transactor.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = WB_DATA_W / 8;

  // Field order fixes the flattened layout: we is the MSB, dat the LSBs.
  typedef struct packed {
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat;
  } wb_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDrain
  } xactor_state_e;

  function automatic int unsigned req_width(input int unsigned aw, input int unsigned dw);
    return 1 + dw / 8 + aw + dw;
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO with flush; the head entry is driven straight from storage registers.
module wb_sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/wishbone_slave_xactor.sv
// Wishbone B4 pipelined slave: queues bus requests to a client get port and turns
// in-order client responses into ACK_O/DAT_O, discarding responses orphaned by an abort.
module wishbone_slave_xactor
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W          = WB_ADDR_W,
  parameter int unsigned DATA_W          = WB_DATA_W,
  parameter int unsigned REQ_DEPTH       = 2,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned SEL_W          = DATA_W / 8,
  localparam int unsigned REQ_W          = req_width(ADDR_W, DATA_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [ADDR_W-1:0] ADR_I,
  input  logic [SEL_W-1:0]  SEL_I,
  input  logic [DATA_W-1:0] DAT_I,
  output logic              STALL_O,
  output logic              ACK_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic [REQ_W-1:0]  client_request_get,
  output logic              RDY_client_request_get,
  input  logic              EN_client_request_get,
  input  logic [DATA_W-1:0] client_response_put,
  input  logic              EN_client_response_put,
  output logic              RDY_client_response_put
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = $clog2(REQ_DEPTH + 1);
  localparam logic [OUT_W-1:0] MaxOut = OUT_W'(MAX_OUTSTANDING);

  xactor_state_e    r_state;
  xactor_state_e    w_state_d;
  logic [OUT_W-1:0] r_outstanding;
  logic [OUT_W-1:0] w_outstanding_d;
  logic [OUT_W-1:0] r_discard;
  logic [OUT_W-1:0] w_discard_d;
  logic [OUT_W-1:0] w_held;
  logic             r_stall;
  logic             w_stall_d;
  logic             r_ack;
  logic [DATA_W-1:0] r_dat;
  logic             w_accept;
  logic             w_abort;
  logic             w_ack_d;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_cnt;
  logic [CNT_W-1:0] w_fifo_cnt_d;

  assign w_accept = CYC_I && STB_I && !r_stall;
  assign w_abort  = !CYC_I && (r_outstanding != '0);
  assign w_ack_d  = EN_client_response_put && CYC_I && (r_discard == '0) &&
                    (r_outstanding != '0);

  wb_sync_fifo #(
    .DEPTH (REQ_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_flush (w_abort),
    .i_push  (w_accept),
    .i_data  ({WE_I, SEL_I, ADR_I, DAT_I}),
    .i_pop   (EN_client_request_get),
    .o_data  (client_request_get),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  // Requests held by the client at abort, including one dequeued in the abort cycle.
  assign w_held = r_outstanding - OUT_W'(w_fifo_cnt) + OUT_W'(EN_client_request_get);

  always_comb begin
    w_outstanding_d = r_outstanding;
    w_discard_d     = r_discard;
    w_fifo_cnt_d    = w_fifo_cnt;
    if (w_abort) begin
      w_outstanding_d = '0;
      w_fifo_cnt_d    = '0;
      w_discard_d     = w_held;
      if (EN_client_response_put && (w_held != '0)) w_discard_d = w_held - OUT_W'(1);
    end else begin
      w_outstanding_d = r_outstanding + OUT_W'(w_accept) - OUT_W'(w_ack_d);
      w_fifo_cnt_d    = w_fifo_cnt + CNT_W'(w_accept) - CNT_W'(EN_client_request_get);
      if (EN_client_response_put && (r_discard != '0)) w_discard_d = r_discard - OUT_W'(1);
    end
    // Stall is registered from next state so it never depends on this cycle's bus inputs.
    w_stall_d = (w_fifo_cnt_d == CNT_W'(REQ_DEPTH)) || (w_outstanding_d == MaxOut) ||
                (w_discard_d != '0);
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StBusy;
      StBusy: begin
        if (w_abort) w_state_d = (w_discard_d != '0) ? StDrain : StIdle;
        else if (w_outstanding_d == '0) w_state_d = StIdle;
      end
      StDrain: if (w_discard_d == '0) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= StIdle;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_stall       <= 1'b1;
      r_ack         <= 1'b0;
      r_dat         <= '0;
    end else begin
      r_state       <= w_state_d;
      r_outstanding <= w_outstanding_d;
      r_discard     <= w_discard_d;
      r_stall       <= w_stall_d;
      r_ack         <= w_ack_d;
      if (w_ack_d) r_dat <= client_response_put;
    end
  end

  assign STALL_O                 = r_stall;
  assign ACK_O                   = r_ack;
  assign DAT_O                   = r_dat;
  assign RDY_client_request_get  = !w_fifo_empty;
  assign RDY_client_response_put = 1'b1;

  a_stall_not_full: assert property (@(posedge CLK) disable iff (RST)
    !STALL_O |-> !w_fifo_full);
  a_ack_has_cyc: assert property (@(posedge CLK) disable iff (RST)
    ACK_O |-> $past(CYC_I));
  a_outstanding_max: assert property (@(posedge CLK) disable iff (RST)
    r_outstanding <= MaxOut);
  a_get_when_rdy: assert property (@(posedge CLK) disable iff (RST)
    EN_client_request_get |-> RDY_client_request_get);
  a_idle_is_clear: assert property (@(posedge CLK) disable iff (RST)
    (r_state == StIdle) |-> (r_outstanding == '0) && (r_discard == '0));

endmodule

// File: tb/tb_wishbone_slave_xactor.sv
// Directed bench for wishbone_slave_xactor: one task per scenario, inline checks.
module tb_wishbone_slave_xactor;
  import wb_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CYC_I, STB_I, WE_I;
  logic [31:0] ADR_I, DAT_I;
  logic [3:0]  SEL_I;
  logic        STALL_O, ACK_O;
  logic [31:0] DAT_O;
  logic [68:0] client_request_get;
  logic        RDY_get, EN_get, RDY_put, EN_put;
  logic [31:0] resp;
  wb_req_t     req;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 CLK = ~CLK;
  assign req = client_request_get;

  wishbone_slave_xactor dut (
    .CLK                     (CLK),
    .RST                     (RST),
    .CYC_I                   (CYC_I),
    .STB_I                   (STB_I),
    .WE_I                    (WE_I),
    .ADR_I                   (ADR_I),
    .SEL_I                   (SEL_I),
    .DAT_I                   (DAT_I),
    .STALL_O                 (STALL_O),
    .ACK_O                   (ACK_O),
    .DAT_O                   (DAT_O),
    .client_request_get      (client_request_get),
    .RDY_client_request_get  (RDY_get),
    .EN_client_request_get   (EN_get),
    .client_response_put     (resp),
    .EN_client_response_put  (EN_put),
    .RDY_client_response_put (RDY_put)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    n_tests++; if (STALL_O !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b want 1", STALL_O); end
    n_tests++; if (ACK_O !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ACK_O); end
    n_tests++; if (DAT_O !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h want 0", DAT_O); end
    n_tests++; if (RDY_get !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_get got %b want 0", RDY_get); end
    n_tests++; if (RDY_put !== 1'b1) begin n_fail++; $display("FAIL rdy_put got %b want 1", RDY_put); end
    RST = 1'b0;
    step();
    n_tests++; if (STALL_O !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall got %b want 0", STALL_O); end
    CYC_I = 1'b0; STB_I = 1'b1; ADR_I = 32'h80;
    step();
    STB_I = 1'b0;
    n_tests++; if (RDY_get !== 1'b0) begin n_fail++; $display("FAIL stb_no_cyc_rdy got %b want 0", RDY_get); end
    n_tests++; if (dut.r_outstanding !== 4'd0) begin n_fail++; $display("FAIL stb_no_cyc_out got %0d want 0", dut.r_outstanding); end
  endtask

  task automatic test_single_read();
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h100; SEL_I = 4'hF; DAT_I = 32'h0;
    step();
    STB_I = 1'b0;
    n_tests++; if (RDY_get !== 1'b1) begin n_fail++; $display("FAIL read_rdy got %b want 1", RDY_get); end
    n_tests++; if ({req.we, req.sel, req.adr} !== {1'b0, 4'hF, 32'h100}) begin
      n_fail++; $display("FAIL read_req got %b/%h/%h want 0/f/00000100", req.we, req.sel, req.adr); end
    n_tests++; if (dut.r_outstanding !== 4'd1) begin n_fail++; $display("FAIL read_out got %0d want 1", dut.r_outstanding); end
    EN_get = 1'b1;
    step();
    EN_get = 1'b0;
    n_tests++; if (RDY_get !== 1'b0) begin n_fail++; $display("FAIL read_deq_rdy got %b want 0", RDY_get); end
    EN_put = 1'b1; resp = 32'hDEADBEEF;
    step();
    EN_put = 1'b0;
    n_tests++; if (ACK_O !== 1'b1) begin n_fail++; $display("FAIL read_ack got %b want 1", ACK_O); end
    n_tests++; if (DAT_O !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_dat got %h want deadbeef", DAT_O); end
    n_tests++; if (dut.r_outstanding !== 4'd0) begin n_fail++; $display("FAIL read_out_end got %0d want 0", dut.r_outstanding); end
    step();
    n_tests++; if (ACK_O !== 1'b0) begin n_fail++; $display("FAIL read_ack_once got %b want 0", ACK_O); end
    n_tests++; if (DAT_O !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_dat_hold got %h want deadbeef", DAT_O); end
  endtask

  task automatic test_back_to_back();
    int   sent;
    int   got;
    logic acc;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; SEL_I = 4'hF;
    ADR_I = 32'h0; DAT_I = 32'hA0;
    step();
    ADR_I = 32'h4; DAT_I = 32'hA1;
    step();
    n_tests++; if (STALL_O !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got %b want 1", STALL_O); end
    ADR_I = 32'h8; DAT_I = 32'hA2;
    step();
    step();
    n_tests++; if (STALL_O !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_hold got %b want 1", STALL_O); end
    n_tests++; if (dut.r_outstanding !== 4'd2) begin n_fail++; $display("FAIL b2b_out got %0d want 2", dut.r_outstanding); end
    sent = 2;
    got  = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      STB_I = (sent < 4);
      ADR_I = 32'(sent * 4);
      DAT_I = 32'hA0 + 32'(sent);
      EN_get = RDY_get;
      if (RDY_get) begin
        n_tests++;
        if ({req.we, req.adr, req.dat} !== {1'b1, 32'(got * 4), 32'hA0 + 32'(got)}) begin
          n_fail++; $display("FAIL b2b_order[%0d] got %b/%h/%h want 1/%h/%h", got, req.we, req.adr,
                             req.dat, 32'(got * 4), 32'hA0 + 32'(got));
        end
      end
      acc = STB_I && !STALL_O;
      step();
      if (acc) sent++;
      if (EN_get) got++;
    end
    EN_get = 1'b0; STB_I = 1'b0;
    n_tests++; if (got != 4 || sent != 4) begin n_fail++; $display("FAIL b2b_delivered got %0d/%0d want 4/4", sent, got); end
    for (int i = 0; i < 4; i++) begin
      EN_put = 1'b1; resp = 32'(i);
      step();
      n_tests++; if (ACK_O !== 1'b1) begin n_fail++; $display("FAIL b2b_ack[%0d] got %b want 1", i, ACK_O); end
    end
    EN_put = 1'b0;
    step();
    n_tests++; if (ACK_O !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_end got %b want 0", ACK_O); end
    n_tests++; if (dut.r_outstanding !== 4'd0) begin n_fail++; $display("FAIL b2b_out_end got %0d want 0", dut.r_outstanding); end
  endtask

  task automatic test_max_outstanding();
    int   sent;
    logic acc;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; SEL_I = 4'hF;
    sent = 0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      ADR_I = 32'h200 + 32'(sent * 4);
      EN_get = RDY_get;
      acc = !STALL_O;
      step();
      if (acc) sent++;
    end
    n_tests++; if (sent != 8) begin n_fail++; $display("FAIL max_sent got %0d want 8", sent); end
    n_tests++; if (STALL_O !== 1'b1) begin n_fail++; $display("FAIL max_stall got %b want 1", STALL_O); end
    repeat (2) begin
      EN_get = RDY_get;
      step();
    end
    EN_get = 1'b0;
    n_tests++; if (STALL_O !== 1'b1) begin n_fail++; $display("FAIL max_stall_hold got %b want 1", STALL_O); end
    n_tests++; if (dut.r_outstanding !== 4'd8) begin n_fail++; $display("FAIL max_out got %0d want 8", dut.r_outstanding); end
    n_tests++; if (RDY_get !== 1'b0) begin n_fail++; $display("FAIL max_drained got %b want 0", RDY_get); end
    EN_put = 1'b1; resp = 32'h55AA0001;
    step();
    EN_put = 1'b0; STB_I = 1'b0;
    n_tests++; if (ACK_O !== 1'b1) begin n_fail++; $display("FAIL max_ack got %b want 1", ACK_O); end
    n_tests++; if (DAT_O !== 32'h55AA0001) begin n_fail++; $display("FAIL max_dat got %h want 55aa0001", DAT_O); end
    n_tests++; if (STALL_O !== 1'b0) begin n_fail++; $display("FAIL max_release got %b want 0", STALL_O); end
    n_tests++; if (dut.r_outstanding !== 4'd7) begin n_fail++; $display("FAIL max_out7 got %0d want 7", dut.r_outstanding); end
    for (int i = 0; i < 7; i++) begin
      EN_put = 1'b1; resp = 32'(i);
      step();
      n_tests++; if (ACK_O !== 1'b1) begin n_fail++; $display("FAIL max_drain_ack[%0d] got %b want 1", i, ACK_O); end
    end
    EN_put = 1'b0;
    step();
    n_tests++; if (dut.r_outstanding !== 4'd0) begin n_fail++; $display("FAIL max_out_end got %0d want 0", dut.r_outstanding); end
  endtask

  task automatic test_abort();
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0;
    ADR_I = 32'h300; EN_get = 1'b0;
    step();
    ADR_I = 32'h304; EN_get = 1'b1;
    step();
    ADR_I = 32'h308; EN_get = 1'b0;
    step();
    n_tests++; if (dut.r_outstanding !== 4'd3) begin n_fail++; $display("FAIL abort_out3 got %0d want 3", dut.r_outstanding); end
    n_tests++; if (STALL_O !== 1'b1) begin n_fail++; $display("FAIL abort_full got %b want 1", STALL_O); end
    CYC_I = 1'b0; STB_I = 1'b0;
    step();
    n_tests++; if (RDY_get !== 1'b0) begin n_fail++; $display("FAIL abort_flush got %b want 0", RDY_get); end
    n_tests++; if (dut.r_discard !== 4'd1) begin n_fail++; $display("FAIL abort_discard got %0d want 1", dut.r_discard); end
    n_tests++; if (dut.r_outstanding !== 4'd0) begin n_fail++; $display("FAIL abort_out got %0d want 0", dut.r_outstanding); end
    step();
    n_tests++; if (STALL_O !== 1'b1) begin n_fail++; $display("FAIL abort_stall got %b want 1", STALL_O); end
    CYC_I = 1'b1; EN_put = 1'b1; resp = 32'h77;
    step();
    EN_put = 1'b0;
    n_tests++; if (ACK_O !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack got %b want 0", ACK_O); end
    n_tests++; if (dut.r_discard !== 4'd0) begin n_fail++; $display("FAIL abort_discard0 got %0d want 0", dut.r_discard); end
    n_tests++; if (STALL_O !== 1'b0) begin n_fail++; $display("FAIL abort_unstall got %b want 0", STALL_O); end
    CYC_I = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h400;
    step();
    STB_I = 1'b0; EN_get = 1'b1;
    step();
    EN_get = 1'b0;
    STB_I = 1'b1; ADR_I = 32'h404; EN_put = 1'b1; resp = 32'hCAFEF00D;
    step();
    STB_I = 1'b0; EN_put = 1'b0;
    n_tests++; if (ACK_O !== 1'b1) begin n_fail++; $display("FAIL simul_ack got %b want 1", ACK_O); end
    n_tests++; if (DAT_O !== 32'hCAFEF00D) begin n_fail++; $display("FAIL simul_dat got %h want cafef00d", DAT_O); end
    n_tests++; if (dut.r_outstanding !== 4'd1) begin n_fail++; $display("FAIL simul_out got %0d want 1", dut.r_outstanding); end
    n_tests++; if (RDY_get !== 1'b1 || req.adr !== 32'h404) begin
      n_fail++; $display("FAIL simul_queued got %b/%h want 1/00000404", RDY_get, req.adr); end
    EN_get = 1'b1;
    step();
    EN_get = 1'b0; EN_put = 1'b1; resp = 32'h0BADCAFE;
    step();
    EN_put = 1'b0;
    n_tests++; if (ACK_O !== 1'b1 || DAT_O !== 32'h0BADCAFE) begin
      n_fail++; $display("FAIL simul_second got %b/%h want 1/0badcafe", ACK_O, DAT_O); end
    n_tests++; if (dut.r_outstanding !== 4'd0) begin n_fail++; $display("FAIL simul_out_end got %0d want 0", dut.r_outstanding); end
    step();
  endtask

  task automatic test_reset_midway();
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h500;
    step();
    ADR_I = 32'h504; EN_get = 1'b1;
    step();
    EN_get = 1'b0; ADR_I = 32'h508; EN_put = 1'b1; resp = 32'h1234;
    step();
    n_tests++; if (ACK_O !== 1'b1 || DAT_O !== 32'h1234 || dut.r_outstanding !== 4'd2) begin
      n_fail++; $display("FAIL rstmid_pre got %b/%h/%0d want 1/00001234/2", ACK_O, DAT_O, dut.r_outstanding); end
    RST = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; EN_put = 1'b0;
    step();
    n_tests++; if (ACK_O !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack got %b want 0", ACK_O); end
    n_tests++; if (RDY_get !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdy got %b want 0", RDY_get); end
    n_tests++; if (STALL_O !== 1'b1) begin n_fail++; $display("FAIL rstmid_stall got %b want 1", STALL_O); end
    n_tests++; if (DAT_O !== 32'h0) begin n_fail++; $display("FAIL rstmid_dat got %h want 0", DAT_O); end
    RST = 1'b0;
    step();
    n_tests++; if (STALL_O !== 1'b0) begin n_fail++; $display("FAIL rstmid_unstall got %b want 0", STALL_O); end
    CYC_I = 1'b1; STB_I = 1'b1; ADR_I = 32'h600;
    step();
    STB_I = 1'b0;
    n_tests++; if (RDY_get !== 1'b1 || req.adr !== 32'h600) begin
      n_fail++; $display("FAIL rstmid_req got %b/%h want 1/00000600", RDY_get, req.adr); end
    EN_get = 1'b1;
    step();
    EN_get = 1'b0; EN_put = 1'b1; resp = 32'hBEEF0001;
    step();
    EN_put = 1'b0;
    n_tests++; if (ACK_O !== 1'b1 || DAT_O !== 32'hBEEF0001) begin
      n_fail++; $display("FAIL rstmid_read got %b/%h want 1/beef0001", ACK_O, DAT_O); end
    step();
    CYC_I = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests", n_tests);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    RST = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    ADR_I = '0; DAT_I = '0; SEL_I = '0; EN_get = 1'b0; EN_put = 1'b0; resp = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_max_outstanding();
    test_abort();
    test_simultaneous();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
